// File: rtl/rv_pkg.sv
// Shared definitions for the RISC-V core front end: data width, reset/NOP
// constants and the fetch sequencer state encoding.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC    = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [XLEN-1:0] INSTR_BYTES = 32'h0000_0004;
    localparam logic [XLEN-1:0] WORD_MASK   = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, drives a single-outstanding handshaked
// instruction memory, applies redirects and holds one registered decode slot.
module fetch_ctrl
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = rv_pkg::RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = rv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_branch_dest,
    input  logic            stall_d,
    output logic            mem_req_valid,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_req_ready,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus_4,
    output logic            stall_f
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            kill_q, kill_d;
    logic            hold_q, hold_d;
    logic [XLEN-1:0] hold_addr_q, hold_addr_d;
    logic            instr_valid_q, instr_valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus_4_q, pc_plus_4_d;

    logic req_accept;
    logic rsp_take;
    logic load;
    logic consume;

    assign req_accept = mem_req_valid & mem_req_ready;
    assign rsp_take   = (state_q == WAIT) & mem_rsp_valid;
    assign load       = rsp_take & ~kill_q & ~pc_src;
    assign consume    = instr_valid_q & ~stall_d;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge values regardless of process order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned
        // and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = REQ;
            REQ:     if (req_accept) state_d = WAIT;
            WAIT:    if (mem_rsp_valid) state_d = REQ;
            default: state_d = BOOT;
        endcase
    end

    // A request already on the bus keeps its address across a redirect.
    always_comb begin
        mem_req_valid = (state_q == REQ) & (hold_q | ~instr_valid_q | ~stall_d);
        mem_req_addr  = hold_q ? hold_addr_q : fetch_pc_q;
        instr_valid   = instr_valid_q;
        instr         = instr_valid_q ? instr_q : NOP_INSTR;
        pc            = pc_q;
        pc_plus_4     = pc_plus_4_q;
        stall_f       = ~instr_valid_q | stall_d;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        kill_d        = kill_q;
        hold_d        = mem_req_valid & ~mem_req_ready;
        hold_addr_d   = mem_req_addr;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        pc_d          = pc_q;
        pc_plus_4_d   = pc_plus_4_q;

        if (consume) begin
            instr_valid_d = 1'b0;
        end

        if (rsp_take) begin
            kill_d = 1'b0;
            if (load) begin
                instr_valid_d = 1'b1;
                instr_d       = mem_rsp_data;
                pc_d          = fetch_pc_q;
                pc_plus_4_d   = fetch_pc_q + INSTR_BYTES;
                fetch_pc_d    = fetch_pc_q + INSTR_BYTES;
            end
        end

        // Redirect wins; only a request already issued or in flight needs a kill.
        if (pc_src) begin
            fetch_pc_d    = pc_branch_dest & WORD_MASK;
            instr_valid_d = 1'b0;
            if (mem_req_valid || ((state_q == WAIT) && !mem_rsp_valid)) begin
                kill_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            kill_q        <= 1'b0;
            hold_q        <= 1'b0;
            hold_addr_q   <= RESET_PC;
            instr_valid_q <= 1'b0;
            instr_q       <= NOP_INSTR;
            pc_q          <= '0;
            pc_plus_4_q   <= INSTR_BYTES;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            kill_q        <= kill_d;
            hold_q        <= hold_d;
            hold_addr_q   <= hold_addr_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            pc_q          <= pc_d;
            pc_plus_4_q   <= pc_plus_4_d;
        end
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch sequencer for the pipelined RISC-V core. It drives a handshaked, variable-latency instruction memory with at most one outstanding request, and owns the fetch PC. It applies branch/jump redirects and presents fetched instructions to decode through a registered valid/stall interface. It also generates stall_f for the hazard logic.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, value driven on instr when instr_valid=0 (addi x0,x0,0)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
pc_src  in  1  redirect request from execute (single-cycle pulse)
pc_branch_dest  in  32  redirect target; bits [1:0] forced to 0
stall_d  in  1  decode cannot accept this cycle
mem_req_valid  out  1  instruction memory request
mem_req_addr  out  32  word-aligned request address
mem_req_ready  in  1  memory accepts request (valid&ready)
mem_rsp_valid  in  1  read data valid; never in the same cycle as acceptance
mem_rsp_data  in  32  instruction word
instr_valid  out  1  instr/pc/pc_plus_4 hold a live instruction
instr  out  32  fetched instruction, NOP_INSTR when invalid
pc  out  32  address of instr
pc_plus_4  out  32  pc + 4, modulo 2^32
stall_f  out  1  = ~instr_valid | stall_d; decode consumes when instr_valid & ~stall_d

Behaviour:
- Reset values: state=BOOT, fetch_pc=RESET_PC, mem_req_valid=0, mem_req_addr=RESET_PC, instr_valid=0, instr=NOP_INSTR, pc=0, pc_plus_4=4, kill=0. Reset may assert in any state. An in-flight response is ignored until a post-reset request is accepted.
- States BOOT, REQ, WAIT:
  - BOOT: one cycle after reset release, then go to REQ.
  - REQ: assert mem_req_valid with addr=fetch_pc only when the output slot is free or is being consumed this cycle (~instr_valid | ~stall_d). Otherwise hold mem_req_valid low. Once mem_req_valid is high, addr is stable until accepted. On valid&ready go to WAIT.
  - WAIT: on mem_rsp_valid with kill=0 and no pc_src this cycle, load instr=data, pc=fetch_pc, pc_plus_4=fetch_pc+4, set instr_valid=1, set fetch_pc+=4 (wraps), and go to REQ. With kill=1 or pc_src, discard the data, clear kill, and go to REQ.
- Output slot: instr_valid clears when consumed with no new load in the same cycle. A load and a consume in the same cycle keeps instr_valid=1 with the new contents.
- Redirect (pc_src=1), which has priority over every other event in the same cycle:
  - fetch_pc <= {dest[31:2],2'b00}, and instr_valid <= 0 (flush).
  - In REQ with the request not yet accepted: keep the old addr until accepted, set kill, and discard that response.
  - In REQ with the request accepted in the same cycle, or in WAIT: set kill.
  - In BOOT, or in REQ with mem_req_valid=0: no kill; the next request uses the new target.
  - A second pc_src before the killed response arrives overwrites fetch_pc. kill stays 1, so only one response is discarded.
- Latency (best case, ready=1, rsp one cycle after accept): pc_src at t → new addr accepted at t+1 → rsp at t+2 → instr_valid at t+3. Without a redirect, throughput is one instruction per 2 cycles.
- Single outstanding request: no new request while in WAIT.

Decomposition:
- Shared package rv_pkg: NOP_INSTR, RESET_PC, fetch state enum (BOOT/REQ/WAIT), XLEN=32.
- No sub-module. A single FSM with the output register slot is inline.

Test Plan:
- Reset: release reset with ready=1 and one-cycle rsp → first accepted addr 0x0, and instr_valid=1 at the 3rd cycle after BOOT with pc=0, pc_plus_4=4. Sequential addrs 0x4, 0x8 follow every 2 cycles.
- Back-pressure: hold stall_d=1 while a fetched instr is valid → mem_req_valid stays 0, and instr/pc are held. Release → the next request is issued in the same cycle.
- Slow memory: hold ready=0 for 3 cycles with pc_src=1 (dest 0x100) during that window → addr holds the old value until accepted, the response is discarded, the next accepted addr is 0x100, and pc=0x100 when valid.
- Redirect in WAIT: pc_src with dest 0x203 while a response is outstanding → the response is dropped, instr_valid=0, the next addr is 0x200, and pc_plus_4=0x204.
- Same cycle: pc_src coincides with mem_rsp_valid → no instr_valid for that data, and the next request goes to the target.
- Wrap: fetch_pc=0xFFFF_FFFC is delivered → pc_plus_4=0x0, and the next request addr is 0x0. Mid-WAIT reset → all outputs return to their reset values, and the first request goes to RESET_PC.
